// File: rtl/sar_adc_mc.sv
// rtl/sar_adc_mc.sv - multi-channel SAR converter with oversampling and round-robin scan
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous active-low reset
//   input_voltage_real    N_CH packed quantised inputs, channel k at [k*VIN_W +: VIN_W]
//   start                 conversion request, honoured only while idle
//   channel_sel           first channel to convert, captured with start
//   avg_log2              oversampling exponent (1/2/4/8 samples), captured with start
//   scan_mode             advance to the next channel after each result
//   busy                  high whenever a conversion or scan is in progress
//   eoc                   one-cycle result strobe
//   output_result_digital averaged result, held until the next eoc
//   output_channel        channel the held result belongs to
module sar_adc_mc #(
  parameter int N_CH   = 4,
  parameter int VIN_W  = 10,
  parameter int N_BITS = 10,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*VIN_W-1:0]  input_voltage_real,
  input  logic                   start,
  input  logic [CH_W-1:0]        channel_sel,
  input  logic [1:0]             avg_log2,
  input  logic                   scan_mode,
  output logic                   busy,
  output logic                   eoc,
  output logic [N_BITS-1:0]      output_result_digital,
  output logic [CH_W-1:0]        output_channel
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAMPLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_ACCUM   = 2'd3;

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  // Eight full-scale samples need three extra bits.
  localparam int ACC_W = N_BITS + 3;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  logic [1:0]        state;
  logic [CH_W-1:0]   ch;
  logic [1:0]        avg;
  logic [ACC_W-1:0]  acc;
  logic [3:0]        cnt;
  logic [N_BITS-1:0] hold;
  logic [N_BITS-1:0] code;
  logic [IDX_W-1:0]  idx;

  // Top N_BITS of every channel; lower bits below the converter resolution are dropped.
  logic [N_BITS-1:0] ch_top [N_CH];
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_top[k] = input_voltage_real[k*VIN_W + (VIN_W - N_BITS) +: N_BITS];
  end

  // Out-of-range channel requests fall back to channel 0.
  function automatic logic [CH_W-1:0] legal_ch(input logic [CH_W-1:0] s);
    legal_ch = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s == CH_W'(k)) legal_ch = s;
    end
  endfunction

  logic [N_BITS-1:0] trial;
  logic [ACC_W-1:0]  acc_next;
  logic [3:0]        cnt_next;
  logic              last_sample;
  logic [N_BITS-1:0] result_next;
  logic [CH_W-1:0]   ch_next;

  always_comb begin
    trial       = code | (N_BITS'(1) << idx);
    acc_next    = acc + ACC_W'(code);
    cnt_next    = cnt + 4'd1;
    last_sample = (cnt_next == (4'd1 << avg));
    result_next = N_BITS'(acc_next >> avg);
    ch_next     = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= S_IDLE;
      ch                    <= '0;
      avg                   <= '0;
      acc                   <= '0;
      cnt                   <= '0;
      hold                  <= '0;
      code                  <= '0;
      idx                   <= '0;
      eoc                   <= 1'b0;
      output_result_digital <= '0;
      output_channel        <= '0;
    end else begin
      eoc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ch    <= legal_ch(channel_sel);
            avg   <= avg_log2;
            acc   <= '0;
            cnt   <= '0;
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          hold  <= ch_top[ch];
          code  <= '0;
          idx   <= IDX_W'(N_BITS - 1);
          state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (hold >= trial) code <= trial;
          if (idx == '0) begin
            state <= S_ACCUM;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: begin  // S_ACCUM
          if (!last_sample) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            state <= S_SAMPLE;
          end else begin
            output_result_digital <= result_next;
            output_channel        <= ch;
            eoc                   <= 1'b1;
            acc                   <= '0;
            cnt                   <= '0;
            if (scan_mode) begin
              ch    <= ch_next;
              state <= S_SAMPLE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_mc.sv
// tb/tb_sar_adc_mc.sv - scoreboard bench for sar_adc_mc
module tb_sar_adc_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] vin;
  logic        start;
  logic [1:0]  channel_sel;
  logic [1:0]  avg_log2;
  logic        scan_mode;
  logic        busy;
  logic        eoc;
  logic [9:0]  result;
  logic [1:0]  out_ch;

  logic [39:0] vin8;
  logic        start8;
  logic        busy8;
  logic        eoc8;
  logic [7:0]  result8;
  logic [1:0]  out_ch8;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0;

  typedef struct {
    logic [9:0] val;
    logic [1:0] ch;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_adc_mc u_dut (
    .clk                   (clk),
    .reset                 (reset),
    .input_voltage_real    (vin),
    .start                 (start),
    .channel_sel           (channel_sel),
    .avg_log2              (avg_log2),
    .scan_mode             (scan_mode),
    .busy                  (busy),
    .eoc                   (eoc),
    .output_result_digital (result),
    .output_channel        (out_ch)
  );

  sar_adc_mc #(.N_CH(4), .VIN_W(10), .N_BITS(8)) u_dut8 (
    .clk                   (clk),
    .reset                 (reset),
    .input_voltage_real    (vin8),
    .start                 (start8),
    .channel_sel           (2'd0),
    .avg_log2              (2'd0),
    .scan_mode             (1'b0),
    .busy                  (busy8),
    .eoc                   (eoc8),
    .output_result_digital (result8),
    .output_channel        (out_ch8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] v, input logic [1:0] c, input int at);
    exp_t e;
    e.val = v;
    e.ch  = c;
    e.at  = at;
    q.push_back(e);
  endtask

  task automatic set_ch(input int k, input logic [9:0] v);
    vin[k*10 +: 10] = v;
  endtask

  // Called at a negedge; returns the cycle stamp of the accepting edge.
  task automatic go(input int chs, input int a, input bit scn, output int stamp);
    channel_sel = chs[1:0];
    avg_log2    = a[1:0];
    scan_mode   = scn;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stamp = cyc;
  endtask

  // Monitors: every eoc must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (eoc) begin
      if (q.size() == 0) begin
        check("unexpected_eoc", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(result), 32'(e.val));
        check("channel", 32'(out_ch), 32'(e.ch));
        check("eoc_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    if (eoc8) begin
      if (q8.size() == 0) begin
        check("unexpected_eoc8", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("result8", 32'(result8), 32'(e.val));
        check("channel8", 32'(out_ch8), 32'(e.ch));
        check("eoc8_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    reset       = 1'b0;
    vin         = '0;
    vin8        = '0;
    start       = 1'b0;
    start8      = 1'b0;
    channel_sel = '0;
    avg_log2    = '0;
    scan_mode   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_eoc", 32'(eoc), 0);
    check("rst_result", 32'(result), 0);
    check("rst_channel", 32'(out_ch), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion, busy window of 12 cycles
    set_ch(2, 10'h2A5);
    go(2, 0, 0, c0);
    push(10'h2A5, 2'd2, c0 + 12);
    check("busy_e0", 32'(busy), 1);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      check("busy_conv", 32'(busy), 1);
    end
    @(negedge clk);
    check("busy_done", 32'(busy), 0);
    @(negedge clk);

    // Input change after the sample edge is ignored
    set_ch(1, 10'h155);
    go(1, 0, 0, c0);
    push(10'h155, 2'd1, c0 + 12);
    @(negedge clk);
    set_ch(1, 10'h3FF);
    repeat (12) @(negedge clk);

    // Averaging of four varying samples
    set_ch(0, 10'd8);
    go(0, 2, 0, c0);
    push(10'd9, 2'd0, c0 + 48);
    @(negedge clk);
    set_ch(0, 10'd9);
    repeat (12) @(negedge clk);
    set_ch(0, 10'd10);
    repeat (12) @(negedge clk);
    set_ch(0, 10'd11);
    repeat (c0 + 48 - cyc) @(negedge clk);
    check("avg4_busy_end", 32'(busy), 0);
    @(negedge clk);

    // Eight full-scale samples must not overflow
    set_ch(0, 10'h3FF);
    go(0, 3, 0, c0);
    push(10'h3FF, 2'd0, c0 + 96);
    repeat (97) @(negedge clk);

    // Scan 3 -> 0 -> 1, stop after the third result
    for (int k = 0; k < 4; k++) set_ch(k, 10'(10'h100 + k));
    go(3, 0, 1, c0);
    push(10'h103, 2'd3, c0 + 12);
    push(10'h100, 2'd0, c0 + 24);
    push(10'h101, 2'd1, c0 + 36);
    repeat (12) @(negedge clk);
    check("scan_busy1", 32'(busy), 1);
    repeat (12) @(negedge clk);
    check("scan_busy2", 32'(busy), 1);
    scan_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("scan_stop", 32'(busy), 0);
    @(negedge clk);

    // Start while busy ignored; start in eoc cycle accepted
    set_ch(2, 10'h1C3);
    go(2, 0, 0, c0);
    push(10'h1C3, 2'd2, c0 + 12);
    repeat (4) @(negedge clk);
    channel_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("eoc_cycle_idle", 32'(busy), 0);
    set_ch(2, 10'h07E);
    go(2, 0, 0, c0);
    push(10'h07E, 2'd2, c0 + 12);
    repeat (12) @(negedge clk);
    check("b2b_busy_end", 32'(busy), 0);
    @(negedge clk);

    // Reset in the middle of a conversion
    set_ch(1, 10'h155);
    go(1, 0, 0, c0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_eoc", 32'(eoc), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_channel", 32'(out_ch), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Reduced resolution keeps the top bits of the input
    vin8[9:0] = 10'h2A7;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    begin
      exp_t e;
      e.val = 10'h0A9;
      e.ch  = 2'd0;
      e.at  = cyc + 10;
      q8.push_back(e);
    end
    repeat (12) @(negedge clk);

    check("queue_drained", 32'(q.size()), 0);
    check("queue8_drained", 32'(q8.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sar_adc_mc.md
# sar_adc_mc

Multi-channel, parametrised successor to the single-channel SAR converter. It samples one of `N_CH` quantised "real" input buses and resolves an `N_BITS` result MSB-first through a binary search. The search uses an internal sample-and-hold, trial DAC and comparator model. Optional power-of-two oversampling averages each result, and a round-robin scan mode converts channels back-to-back without software restarts. The block sits between the analog front-end stubs and the digital control/readout logic.

## Interface
- `N_CH`, 4: number of input channels (≥2).
- `VIN_W`, 10: width of each input voltage bus.
- `N_BITS`, 10: conversion resolution (1 ≤ `N_BITS` ≤ `VIN_W`).
- `CH_W`, `$clog2(N_CH)`: channel index width (derived).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `input_voltage_real`  in  `N_CH*VIN_W`  packed channel inputs; channel k at bits `[k*VIN_W +: VIN_W]`.
- `start`  in  1  conversion request; accepted only in IDLE.
- `channel_sel`  in  `CH_W`  first channel; captured on accepted start.
- `avg_log2`  in  2  oversampling: 2^avg_log2 samples (1,2,4,8); captured on accepted start.
- `scan_mode`  in  1  continue to next channel after each result; sampled at each result.
- `busy`  out  1  high in every state except IDLE.
- `eoc`  out  1  one-cycle pulse; result valid.
- `output_result_digital`  out  `N_BITS`  averaged result; holds until next eoc.
- `output_channel`  out  `CH_W`  channel of current result.

## Operation
- States: IDLE, SAMPLE, CONVERT, ACCUM.
- IDLE: `start`=1 at an edge latches `channel_sel`, `avg_log2`, clears the accumulator and sample counter, and goes to SAMPLE. `channel_sel` ≥ `N_CH` is treated as 0.
- SAMPLE (1 cycle): the leaving edge latches `hold = vin[ch][VIN_W-1 -: N_BITS]`, clears the trial code and sets the bit index to `N_BITS-1`.
- CONVERT (`N_BITS` cycles): each edge evaluates `trial = code | (1<<idx)`. If `hold >= trial` (comparator true), `code` takes `trial`; otherwise bit `idx` stays 0. `idx` then decrements. After idx 0, go to ACCUM. The final code equals `hold`.
- ACCUM (1 cycle): `acc += code` (acc width `N_BITS+3`); sample counter +1.
  - If fewer than 2^avg_log2 samples have been taken: go to SAMPLE on the same channel.
  - Otherwise, on the leaving edge: `output_result_digital <= acc >> avg_log2` (floor), `output_channel <= ch`, `eoc <= 1`.
  - Then, if `scan_mode`=1: `ch <= (ch==N_CH-1) ? 0 : ch+1`, clear acc/counter, go to SAMPLE.
  - If `scan_mode`=0: go to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- `avg_log2` and `channel_sel` changes during a conversion have no effect. A scan keeps the `avg_log2` latched at its start.
- Input changes after the SAMPLE edge do not affect that sample.

## Timing
- Reset (asynchronous assert, any state): state IDLE, `busy`=0, `eoc`=0, `output_result_digital`=0, `output_channel`=0, internal registers 0. An in-flight conversion is discarded; no eoc. Reset release is synchronous to `clk`.
- Let E0 be the edge that accepts `start`.
  - Per-sample period: `N_BITS+2` cycles. Total latency: `2^a*(N_BITS+2)` edges.
  - `eoc` is high in the cycle after edge E(2^a·(N_BITS+2)), and the result is valid in that same cycle.
  - Example: `N_BITS`=10, a=0 → eoc after E12.
- `busy` rises after E0 and falls after the final ACCUM edge when not scanning. `eoc` and `busy`=0 are concurrent in that cycle.
- `start` high in the eoc cycle (state IDLE) is accepted. The back-to-back period is `N_BITS+3` cycles including the IDLE cycle.
- Scan: consecutive eoc pulses are exactly `2^a*(N_BITS+2)` cycles apart. `busy` stays high. Dropping `scan_mode` ends the scan at the next result.
- No combinational path from any input to any output.

## Test plan
- Single conversion, N_BITS=10, a=0, ch2 = 0x2A5, start at E0 → `busy` set for 12 cycles; `eoc` for one cycle after E12; result 0x2A5; `output_channel`=2.
- Hold check: ch1 = 0x155 at SAMPLE, changed to 0x3FF during CONVERT → result 0x155.
- Averaging a=2: ch0 = 8, 9, 10, 11 across the four SAMPLE windows → result floor(38/4)=9; eoc after E48; a=3 with constant 0x3FF → 0x3FF (no overflow).
- Scan wrap, N_CH=4: start ch3, scan_mode=1, channel k = 0x100+k → results for ch 3,0,1 with values 0x103,0x100,0x101, eoc spaced 12 cycles. Dropping scan_mode before the third result → IDLE after it.
- Start while busy: second start at E5 ignored → single eoc at E12. Start in the eoc cycle → accepted; next eoc 13 cycles later.
- Reset mid-CONVERT at cycle 6 → outputs zero immediately, no eoc. Variant N_BITS=8, VIN_W=10, ch0=0x2A7 → result 0xA9.
